// File: rtl/stream_fifo_if.sv
// Handshake bundle for stream_fifo: the master drives writes, reads and control;
// the slave (the FIFO) returns data, occupancy and status flags.
interface stream_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                  flush;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  rd_en;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [AW:0]           count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_data, wr_en, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_data, wr_en, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO with standard or first-word-fall-through read, occupancy flags and flush.
// Sticky overflow/underflow flags exist only when STREAM_FIFO_ERR_EN is defined.
module stream_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input logic          clk,
    input logic          rst_n,
    stream_fifo_if.slave bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr, count_r;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_valid_r;
    logic                  wr_acc, rd_acc, mem_pop, rd_valid_nxt;
    logic                  full_w, empty_w, mem_empty;

    assign full_w    = (count_r == DEPTH_C);
    assign mem_empty = (wr_ptr == rd_ptr);
    // In FWFT mode a word still in memory is not yet readable, so empty follows rd_valid.
    assign empty_w   = (FWFT != 0) ? !rd_valid_r : (count_r == '0);

    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wr_acc       = bus.wr_en && !full_w && !bus.flush;
        rd_acc       = bus.rd_en && !empty_w && !bus.flush;
        mem_pop      = rd_acc;
        rd_valid_nxt = rd_acc;
        if (FWFT != 0) begin
            mem_pop      = (!rd_valid_r || rd_acc) && !mem_empty && !bus.flush;
            rd_valid_nxt = mem_pop || (rd_valid_r && !rd_acc);
        end
        if (bus.flush) rd_valid_nxt = 1'b0;
    end

    // NOTE: storage has no reset; resetting the pointers is what discards the contents.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (mem_pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rd_data_r <= mem[rd_ptr[AW-1:0]];
            end
            rd_valid_r <= rd_valid_nxt;
            case ({wr_acc, rd_acc})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.rd_data      = rd_data_r;
    assign bus.rd_valid     = rd_valid_r;
    assign bus.count        = count_r;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_r >= AF_C);
    assign bus.almost_empty = (count_r <= AE_C);

`ifdef STREAM_FIFO_ERR_EN
    logic overflow_r, underflow_r;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= (bus.wr_en && full_w && !bus.flush) || (overflow_r && !bus.err_clr);
            underflow_r <= (bus.rd_en && empty_w && !bus.flush) || (underflow_r && !bus.err_clr);
        end
    end

    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_stream_fifo.sv
// Drives a standard-mode and an FWFT-mode stream_fifo with identical stimulus and
// compares both against queue-based reference models.
module tb_stream_fifo;
    localparam int DW = 32;
    localparam int D  = 16;
    localparam int AF = 12;
    localparam int AE = 4;
`ifdef STREAM_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus_s ();
    stream_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) bus_f ();

    stream_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT(0),
                  .AFULL_THRESH(AF), .AEMPTY_THRESH(AE))
        u_std (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    stream_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT(1),
                  .AFULL_THRESH(AF), .AEMPTY_THRESH(AE))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(bus_f));

    int vectors     = 0;
    int miscompares = 0;

    logic          wr_en, rd_en, flush, err_clr;
    logic [DW-1:0] wr_data;

    // Reference state: word queues, presented/pulse flags, last std read word, sticky errors.
    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_f[$];
    bit            v_f, rv_s, ov_s, un_s, ov_f, un_f;
    logic [DW-1:0] rd_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_s.delete();
        q_f.delete();
        v_f  = 1'b0;
        rv_s = 1'b0;
        rd_s = '0;
        ov_s = 1'b0; un_s = 1'b0;
        ov_f = 1'b0; un_f = 1'b0;
    endtask

    task automatic model_edge();
        int  old;
        bit  pop, ovset, unset;
        // standard mode
        old   = q_s.size();
        ovset = !flush && wr_en && (old == D);
        unset = !flush && rd_en && (old == 0);
        ov_s  = ERR_EN && (ovset || (ov_s && !err_clr));
        un_s  = ERR_EN && (unset || (un_s && !err_clr));
        if (flush) begin
            q_s.delete();
            rv_s = 1'b0;
        end else begin
            rv_s = rd_en && (old > 0);
            if (rv_s) rd_s = q_s.pop_front();
            if (wr_en && old < D) q_s.push_back(wr_data);
        end
        // FWFT mode: a word becomes visible one edge after it was stored
        old   = q_f.size();
        ovset = !flush && wr_en && (old == D);
        unset = !flush && rd_en && !v_f;
        ov_f  = ERR_EN && (ovset || (ov_f && !err_clr));
        un_f  = ERR_EN && (unset || (un_f && !err_clr));
        if (flush) begin
            q_f.delete();
            v_f = 1'b0;
        end else begin
            pop = rd_en && v_f;
            if (pop) void'(q_f.pop_front());
            v_f = (old - int'(pop)) > 0;
            if (wr_en && old < D) q_f.push_back(wr_data);
        end
    endtask

    task automatic check_all();
        check("std count",    bus_s.count,        32'(q_s.size()));
        check("std empty",    bus_s.empty,        32'(q_s.size() == 0));
        check("std full",     bus_s.full,         32'(q_s.size() == D));
        check("std afull",    bus_s.almost_full,  32'(q_s.size() >= AF));
        check("std aempty",   bus_s.almost_empty, 32'(q_s.size() <= AE));
        check("std rd_valid", bus_s.rd_valid,     32'(rv_s));
        check("std rd_data",  bus_s.rd_data,      rd_s);
        check("std ovf",      bus_s.overflow,     32'(ov_s));
        check("std unf",      bus_s.underflow,    32'(un_s));
        check("fw count",     bus_f.count,        32'(q_f.size()));
        check("fw empty",     bus_f.empty,        32'(!v_f));
        check("fw full",      bus_f.full,         32'(q_f.size() == D));
        check("fw afull",     bus_f.almost_full,  32'(q_f.size() >= AF));
        check("fw aempty",    bus_f.almost_empty, 32'(q_f.size() <= AE));
        check("fw rd_valid",  bus_f.rd_valid,     32'(v_f));
        if (v_f) check("fw rd_data", bus_f.rd_data, q_f[0]);
        check("fw ovf",       bus_f.overflow,     32'(ov_f));
        check("fw unf",       bus_f.underflow,    32'(un_f));
    endtask

    task automatic apply();
        bus_s.wr_en = wr_en; bus_s.wr_data = wr_data; bus_s.rd_en = rd_en;
        bus_s.flush = flush; bus_s.err_clr = err_clr;
        bus_f.wr_en = wr_en; bus_f.wr_data = wr_data; bus_f.rd_en = rd_en;
        bus_f.flush = flush; bus_f.err_clr = err_clr;
    endtask

    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit c);
        wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = c;
        apply();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0; wr_data = '0;
        apply();
        model_reset();
        #12;
        check_all();
        check("fw rd_data reset", bus_f.rd_data, 32'h0);
        rst_n = 1'b1;

        // fill to capacity, then one rejected write
        for (int i = 0; i < D; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        check("std full at depth", bus_s.full, 32'h1);
        check("fw count at depth", bus_f.count, 32'd16);
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        check("std overflow", bus_s.overflow, 32'(ERR_EN));
        for (int i = 0; i < D; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("std order", bus_s.rd_data, 32'(i));
        end
        check("std empty drained", bus_s.empty, 32'h1);
        check("fw empty drained", bus_f.empty, 32'h1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // FWFT latency and no-bubble pop
        step(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
        check("fw valid after k", bus_f.rd_valid, 32'h0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("fw valid after k+1", bus_f.rd_valid, 32'h1);
        check("fw data A5", bus_f.rd_data, 32'hA5);
        step(1'b1, 32'hB6, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("fw data B6", bus_f.rd_data, 32'hB6);
        check("fw valid B6", bus_f.rd_valid, 32'h1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // steady simultaneous read/write across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
            check("std count steady", bus_s.count, 32'd8);
            check("fw count steady", bus_f.count, 32'd8);
        end

        // flush at count 10 with concurrent requests
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check("std count 10", bus_s.count, 32'd10);
        step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        check("std flush count", bus_s.count, 32'd0);
        check("fw flush empty", bus_f.empty, 32'h1);
        check("fw flush valid", bus_f.rd_valid, 32'h0);
        check("std flush ovf", bus_s.overflow, 32'h0);
        check("fw flush unf", bus_f.underflow, 32'h0);

        // underflow, clear-vs-set priority, clear
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("std underflow", bus_s.underflow, 32'(ERR_EN));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("fw underflow held", bus_f.underflow, 32'(ERR_EN));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("std underflow clr", bus_s.underflow, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);

        // asynchronous reset at count 5
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check("std count 5", bus_s.count, 32'd5);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("fw rd_data async rst", bus_f.rd_data, 32'h0);
        #2 rst_n = 1'b1;
        step(1'b1, 32'h5A, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("std post-reset data", bus_s.rd_data, 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous FIFO with standard and first-word-fall-through (FWFT) read modes, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and sticky error flags. It buffers packet words between AXI-Lite-facing logic and the validator/sorter datapath, and replaces the fixed-behaviour buffer wherever lookahead, back-pressure thresholds or error reporting are needed.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits
- FIFO_DEPTH, 16, capacity in words; power of two, at least 2
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- AFULL_THRESH, 12, almost_full asserts when count >= this value
- AEMPTY_THRESH, 4, almost_empty asserts when count <= this value

Ports (AW = $clog2(FIFO_DEPTH)):
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous clear of contents
- wr_data  in  DATA_WIDTH  write word
- wr_en  in  1  write request
- rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  rd_data holds a valid word
- full  out  1  count == FIFO_DEPTH
- empty  out  1  no word readable
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  AW+1  words held, including any word in the FWFT output register
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  clears overflow and underflow

## Operation
- Write accepted iff wr_en && !full && !flush; word stored, count +1.
- Standard mode: read accepted iff rd_en && !empty && !flush; head word loaded into rd_data, rd_valid pulses high one cycle; rd_data holds its value otherwise. empty = (count == 0).
- FWFT mode: head word is presented on rd_data with rd_valid high without a request; rd_en while rd_valid pops it and the next word, if any, appears the following cycle with no bubble. empty = !rd_valid.
- Capacity is FIFO_DEPTH in both modes; full/almost flags are derived from count.
- Simultaneous accepted read and write: count unchanged. Write while full is rejected even if a read is accepted in the same cycle. Read while empty is ignored even if a write is accepted in the same cycle.
- Pointers are AW+1 bits and wrap modulo 2*FIFO_DEPTH; memory is indexed by the low AW bits.
- flush takes priority over everything else: pointers, count and rd_valid go to 0; rd_data holds its value; error flags are unaffected; wr_en/rd_en in that cycle are ignored and raise no error.
- overflow is set on wr_en && full; underflow is set on rd_en && empty (both qualified by !flush). err_clr clears both; if a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values: rd_data 0, rd_valid 0, count 0, empty 1, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0.
- Write accepted at edge k: count and empty update after edge k.
- Standard read accepted at edge k: rd_data and rd_valid are valid after edge k.
- FWFT: a write at edge k into an empty FIFO gives rd_valid high after edge k+1. A pop at edge k presents the next word after edge k.
- All flags are registered or decoded from registered count; there is no combinational path from any input to any output.
- rst_n asserted mid-operation: all state returns to its reset values immediately; contents are discarded.

## Configuration
- STREAM_FIFO_ERR_EN defined: overflow/underflow logic is present as described above.
- Not defined: overflow and underflow are tied to 0, err_clr is ignored, and no error registers are synthesised. The port list is identical in both cases.

## Test plan
- Defaults, FWFT=0: write 16 words 0x0..0xF → full=1, count=16, almost_full from count 12; a 17th write sets overflow=1 and is dropped; reading out returns 0x0..0xF in order and empty=1 at the end.
- FWFT=1: write 0xA5 at edge k → rd_valid=1 and rd_data=0xA5 after edge k+1; pop with 0xB6 queued → 0xB6 is presented the next cycle.
- Simultaneous rd_en/wr_en at count=8 for 32 cycles → count stays 8, data order preserved across pointer wrap.
- flush at count=10 together with wr_en and rd_en → count=0, empty=1, rd_valid=0, no error flag set.
- rd_en while empty → underflow=1; err_clr together with a new underflow → underflow stays 1; err_clr alone → 0. With STREAM_FIFO_ERR_EN undefined, both flags stay 0.
- rst_n pulsed low at count=5 → all outputs return to their reset values asynchronously.
